// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word reads and buffers returned words for decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_INC   = 1,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              kill;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];

  logic          fifo_nonempty;
  logic          resp_valid;
  logic          pop;
  logic          issue;
  logic          push_fifo;
  logic          pop_fifo;
  logic [CW:0]   occupancy;

  // The returning word bypasses the buffer when it is empty, giving one cycle addr->valid latency.
  always_comb begin
    fifo_nonempty = (count != '0);
    resp_valid    = inflight && !kill;
    instr_valid   = fifo_nonempty || resp_valid;
    pop           = instr_valid && instr_ready;
    occupancy     = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue         = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    imem_req      = issue;
    imem_addr     = rst_n ? fetch_pc : '0;
    push_fifo     = resp_valid && !(pop && !fifo_nonempty);
    pop_fifo      = pop && fifo_nonempty;
    instr_data    = '0;
    instr_pc      = '0;
    if (fifo_nonempty) begin
      instr_data = buf_data[rd_ptr];
      instr_pc   = buf_pc[rd_ptr];
    end else if (resp_valid) begin
      instr_data = imem_rdata;
      instr_pc   = inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        kill     <= inflight;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        kill <= 1'b0;
        if (push_fifo) wr_ptr <= wr_ptr + PW'(1);
        if (pop_fifo)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_fifo) - CW'(pop_fifo);
      end
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_fifo && !redirect_valid) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && !redirect_valid && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (!instr_valid && perf_stall != '1)             perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit; memory returns addr+0xA0 one cycle after a request.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        imem_rdata <= '0;
    else if (imem_req) imem_rdata <= imem_addr + 32'hA0;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc, input logic [31:0] data);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    bit seen;
    int wait_cycles;

    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //   rst rdy rv rpc             req addr          vld pc            data
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h0,        0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h1,        1, 32'h0,        32'hA0);
    add(1, 1, 0, 32'h0,          1, 32'h2,        1, 32'h1,        32'hA1);
    add(1, 1, 0, 32'h0,          1, 32'h3,        1, 32'h2,        32'hA2);
    add(1, 0, 0, 32'h0,          1, 32'h4,        1, 32'h3,        32'hA3);
    add(1, 0, 0, 32'h0,          0, 32'h5,        1, 32'h3,        32'hA3);
    add(1, 0, 0, 32'h0,          0, 32'h5,        1, 32'h3,        32'hA3);
    add(1, 0, 0, 32'h0,          0, 32'h5,        1, 32'h3,        32'hA3);
    add(1, 0, 0, 32'h0,          0, 32'h5,        1, 32'h3,        32'hA3);
    add(1, 1, 0, 32'h0,          1, 32'h5,        1, 32'h3,        32'hA3);
    add(1, 1, 0, 32'h0,          1, 32'h6,        1, 32'h4,        32'hA4);
    add(1, 1, 0, 32'h0,          1, 32'h7,        1, 32'h5,        32'hA5);
    add(1, 1, 1, 32'h40,         0, 32'h8,        1, 32'h6,        32'hA6);
    add(1, 1, 0, 32'h0,          1, 32'h40,       0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h41,       1, 32'h40,       32'hE0);
    add(1, 1, 0, 32'h0,          1, 32'h42,       1, 32'h41,       32'hE1);
    add(1, 1, 1, 32'h10,         0, 32'h43,       1, 32'h42,       32'hE2);
    add(1, 1, 1, 32'h20,         0, 32'h10,       0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h20,       0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h21,       1, 32'h20,       32'hC0);
    add(1, 1, 1, 32'hFFFFFFFF,   0, 32'h22,       1, 32'h21,       32'hC1);
    add(1, 1, 0, 32'h0,          1, 32'hFFFFFFFF, 0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h0,        1, 32'hFFFFFFFF, 32'h9F);
    add(1, 1, 0, 32'h0,          1, 32'h1,        1, 32'h0,        32'hA0);
    add(1, 0, 0, 32'h0,          1, 32'h2,        1, 32'h1,        32'hA1);
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h0,        0, 32'h0,        32'h0);
    add(1, 1, 0, 32'h0,          1, 32'h1,        1, 32'h0,        32'hA0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n          = vecs[i].rst;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      tests_run++;
      if (imem_req !== vecs[i].req || imem_addr !== vecs[i].addr || instr_valid !== vecs[i].vld ||
          instr_pc !== vecs[i].pc || instr_data !== vecs[i].data) begin
        tests_failed++;
        $display("FAIL vec%0d: got req=%0b addr=%h vld=%0b pc=%h data=%h, expected req=%0b addr=%h vld=%0b pc=%h data=%h",
                 i, imem_req, imem_addr, instr_valid, instr_pc, instr_data,
                 vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].pc, vecs[i].data);
      end
`ifdef IFU_PERF_CNT_EN
      if (i == 28) begin
        check("perf_fetched_reset", perf_fetched, 32'h0);
        check("perf_stall_reset", perf_stall, 32'h0);
      end
`endif
    end

    // Redirect while a fetch is in flight, then wait (bounded) for the new stream.
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
    #1;
    check("redirect_req_low", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0;
    seen = 1'b0;
    wait_cycles = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      #1;
      if (instr_valid) begin
        seen = 1'b1;
        wait_cycles = c;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL redirect_timeout: instr_valid never rose, expected within 8 cycles");
    end else begin
      check("redirect_latency", wait_cycles, 32'd2);
      check("redirect_pc", instr_pc, 32'h100);
      check("redirect_data", instr_data, 32'h1A0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
